// File: rtl/lynxTypes.sv
// Shared DMA command/completion types and sizing constants.
// popcount_keep turns a stream byte-enable mask into a byte count.
package lynxTypes;

  localparam int AXI_DATA_BITS = 512;
  localparam int LEN_BITS      = 28;
  localparam int N_OUTSTANDING = 8;
  localparam int KEEP_MAX      = AXI_DATA_BITS / 8;
  localparam int KEEP_CNT_W    = $clog2(KEEP_MAX) + 1;

  typedef struct packed {
    logic [6:0]          rsvd;
    logic [47:0]         vaddr;
    logic [LEN_BITS-1:0] len;
    logic                ctl;
    logic                host;
    logic                stream;
    logic [3:0]          dest;
    logic [5:0]          pid;
  } dma_req_t;

  typedef struct packed {
    logic       done;
    logic       host;
    logic       stream;
    logic [3:0] dest;
    logic [5:0] pid;
  } dma_rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RETIRE = 2'd2,
    ST_RESP   = 2'd3
  } trk_state_e;

  function automatic logic [KEEP_CNT_W-1:0] popcount_keep(input logic [KEEP_MAX-1:0] keep);
    logic [KEEP_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      n = n + KEEP_CNT_W'(keep[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/dma_wr_cmpl_tracker_fifo.sv
// Generic synchronous FIFO with occupancy count; DEPTH must be a power of two.
// Overflowing pushes and underflowing pops are ignored.
module cmd_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_wr_cmpl_tracker.sv
// Tracks issued DMA write commands against the passing data stream and
// retires each one once its byte count is reached, optionally emitting a completion.
module dma_wr_cmpl_tracker #(
  parameter int N_OUTSTANDING = lynxTypes::N_OUTSTANDING,
  parameter int DATA_BITS     = lynxTypes::AXI_DATA_BITS,
  parameter int LEN_W         = lynxTypes::LEN_BITS
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic                                s_req_valid,
  output logic                                s_req_ready,
  input  lynxTypes::dma_req_t                 s_req_data,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic [DATA_BITS-1:0]                s_axis_tdata,
  input  logic [DATA_BITS/8-1:0]              s_axis_tkeep,
  input  logic                                s_axis_tlast,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [DATA_BITS-1:0]                m_axis_tdata,
  output logic [DATA_BITS/8-1:0]              m_axis_tkeep,
  output logic                                m_axis_tlast,
  output logic                                m_rsp_valid,
  input  logic                                m_rsp_ready,
  output lynxTypes::dma_rsp_t                 m_rsp_data,
  output logic                                err_overrun,
  output logic                                err_early_last,
  output logic [$clog2(N_OUTSTANDING):0]      outstanding
);

  import lynxTypes::*;

  localparam int OCC_W = $clog2(N_OUTSTANDING) + 1;
  localparam int CNT_W = LEN_W + 1;

  logic [1:0]       rst_sync;
  logic             rst_int;
  trk_state_e       state;
  trk_state_e       state_nxt;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] byte_cnt_nxt;
  logic [CNT_W-1:0] beat_bytes;
  logic [CNT_W-1:0] sum;
  logic [CNT_W-1:0] head_len;
  dma_req_t         head;
  dma_rsp_t         rsp_reg;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OCC_W-1:0] occ;
  logic             push;
  logic             pop;
  logic             data_en;
  logic             beat;
  logic             set_overrun;
  logic             set_early;
  logic             load_rsp;
  logic             unused_head;

  // Assert immediately with areset, release two clocks later in aclk's domain
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rst_sync <= 2'b11;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end
  assign rst_int = rst_sync[1];

  assign s_req_ready = !rst_int && !fifo_full;
  assign push        = s_req_valid && s_req_ready;

  cmd_fifo_sync #(
    .WIDTH ($bits(dma_req_t)),
    .DEPTH (N_OUTSTANDING)
  ) u_cmd_fifo (
    .clk   (aclk),
    .rst   (rst_int),
    .push  (push),
    .din   (s_req_data),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occ)
  );

  assign unused_head = &{1'b0, head.vaddr, head.rsvd};
  assign head_len    = CNT_W'(head.len);

  // A zero-length head reached by chaining must not swallow a beat
  assign data_en       = (state == ST_ACTIVE) && (head_len != '0);
  assign m_axis_tvalid = s_axis_tvalid && data_en;
  assign s_axis_tready = m_axis_tready && data_en;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;

  assign beat       = s_axis_tvalid && s_axis_tready;
  assign beat_bytes = CNT_W'(popcount_keep(KEEP_MAX'(s_axis_tkeep)));
  assign sum        = byte_cnt + beat_bytes;

  // Next-state, byte accounting and retire decisions
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    pop          = 1'b0;
    set_overrun  = 1'b0;
    set_early    = 1'b0;
    load_rsp     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = (head_len == '0) ? ST_RETIRE : ST_ACTIVE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (head_len == '0) begin
          state_nxt = ST_RETIRE;
        end else if (beat) begin
          if (sum >= head_len) begin
            state_nxt    = ST_RETIRE;
            byte_cnt_nxt = '0;
            set_overrun  = (sum > head_len);
          end else begin
            byte_cnt_nxt = sum;
            set_early    = s_axis_tlast;
          end
        end else begin
          state_nxt = ST_ACTIVE;
        end
      end
      ST_RETIRE: begin
        pop = 1'b1;
        if (head.ctl) begin
          load_rsp  = 1'b1;
          state_nxt = ST_RESP;
        end else if (occ > OCC_W'(1)) begin
          state_nxt = ST_ACTIVE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (m_rsp_ready) begin
          state_nxt = fifo_empty ? ST_IDLE : ST_ACTIVE;
        end else begin
          state_nxt = ST_RESP;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, byte counter, sticky errors and the held completion
  always_ff @(posedge aclk or posedge rst_int) begin
    if (rst_int) begin
      state          <= ST_IDLE;
      byte_cnt       <= '0;
      err_overrun    <= 1'b0;
      err_early_last <= 1'b0;
      rsp_reg        <= '0;
    end else begin
      state          <= state_nxt;
      byte_cnt       <= byte_cnt_nxt;
      err_overrun    <= err_overrun || set_overrun;
      err_early_last <= err_early_last || set_early;
      if (load_rsp) begin
        rsp_reg <= '{done: 1'b1, host: head.host, stream: head.stream,
                     dest: head.dest, pid: head.pid};
      end else begin
        rsp_reg <= rsp_reg;
      end
    end
  end

  assign m_rsp_valid = (state == ST_RESP);
  assign m_rsp_data  = rsp_reg;
  assign outstanding = occ;

endmodule

// File: tb/tb_dma_wr_cmpl_tracker.sv
// Self-checking bench: directed table, multi-cycle corner sequences and a
// randomized run scored against a byte-accounting model of the command queue.
module tb_dma_wr_cmpl_tracker;
  import lynxTypes::*;

  localparam int DW = 512;
  localparam int KW = DW / 8;

  logic          aclk;
  logic          areset;
  logic          s_req_valid;
  logic          s_req_ready;
  dma_req_t      s_req_data;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_rsp_valid;
  logic          m_rsp_ready;
  dma_rsp_t      m_rsp_data;
  logic          err_overrun;
  logic          err_early_last;
  logic [3:0]    outstanding;

  int n_pass;
  int n_total;

  dma_wr_cmpl_tracker dut (
    .aclk           (aclk),
    .areset         (areset),
    .s_req_valid    (s_req_valid),
    .s_req_ready    (s_req_ready),
    .s_req_data     (s_req_data),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tlast   (m_axis_tlast),
    .m_rsp_valid    (m_rsp_valid),
    .m_rsp_ready    (m_rsp_ready),
    .m_rsp_data     (m_rsp_data),
    .err_overrun    (err_overrun),
    .err_early_last (err_early_last),
    .outstanding    (outstanding)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [27:0] len;
    logic        ctl;
    logic        host;
    logic        stream;
    logic [3:0]  dest;
    logic [5:0]  pid;
    int          nb;
    int          b0;
    int          b1;
    logic [1:0]  last;
    logic        eo;
    logic        ee;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [KW-1:0] make_keep(input int k);
    logic [KW-1:0] m;
    m = '0;
    for (int i = 0; i < KW; i++) if (i < k) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic dma_req_t mk_req(input logic [27:0] len, input logic ctl, input logic host,
                                      input logic stream, input logic [3:0] dest, input logic [5:0] pid);
    dma_req_t r;
    r = '0;
    r.vaddr = {16'h0, $urandom};
    r.len = len; r.ctl = ctl; r.host = host; r.stream = stream; r.dest = dest; r.pid = pid;
    return r;
  endfunction

  function automatic dma_rsp_t rsp_of(input dma_req_t r);
    dma_rsp_t p;
    p.done = 1'b1; p.host = r.host; p.stream = r.stream; p.dest = r.dest; p.pid = r.pid;
    return p;
  endfunction

  task automatic push_cmd(input dma_req_t c);
    int w;
    w = 0;
    s_req_valid = 1'b1;
    s_req_data  = c;
    #1;
    while (!s_req_ready && w < 20) begin tick(); w++; end
    check("push_ready", 64'(s_req_ready), 64'd1);
    tick();
    s_req_valid = 1'b0;
  endtask

  // Drives one beat, waits (bounded) for acceptance and checks the forwarded copy.
  task automatic send_beat(input logic [KW-1:0] keep, input logic last);
    int w;
    logic [DW-1:0] dat;
    w = 0;
    dat = rand_data();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = dat;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    #1;
    while (!s_axis_tready && w < 20) begin tick(); w++; end
    check("beat_accept", 64'(s_axis_tready), 64'd1);
    check("fwd", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata === dat, m_axis_tkeep === keep}),
          64'({1'b1, last, 1'b1, 1'b1}));
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input dma_rsp_t exp, input int bound);
    int w;
    w = 0;
    while (!m_rsp_valid && w < bound) begin tick(); w++; end
    check({name, "_valid"}, 64'(m_rsp_valid), 64'd1);
    check({name, "_data"}, 64'(m_rsp_data), 64'(exp));
    m_rsp_ready = 1'b1;
    #1;
    tick();
    m_rsp_ready = 1'b0;
  endtask

  initial begin
    vec_t     vecs [5];
    dma_req_t c;
    dma_req_t ca;
    dma_req_t cb;
    dma_req_t model_q [$];
    dma_rsp_t held;
    logic [KW-1:0] keep;
    int acc, bytes, seen, bad, n, cnt;
    logic saw, tr, last, m_ovr, m_early;

    n_pass = 0; n_total = 0;
    areset = 1'b1; s_req_valid = 1'b0; s_req_data = '0;
    s_axis_tvalid = 1'b1; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1; m_rsp_ready = 1'b0;

    vecs[0] = '{28'd128, 1'b1, 1'b0, 1'b0, 4'd2,  6'd5,  2, 64, 64, 2'b10, 1'b0, 1'b0};
    vecs[1] = '{28'd100, 1'b1, 1'b0, 1'b1, 4'd1,  6'd9,  2, 64, 36, 2'b10, 1'b0, 1'b0};
    vecs[2] = '{28'd100, 1'b1, 1'b1, 1'b0, 4'd7,  6'd3,  2, 64, 40, 2'b10, 1'b1, 1'b0};
    vecs[3] = '{28'd128, 1'b1, 1'b0, 1'b0, 4'd4,  6'd12, 2, 64, 64, 2'b11, 1'b1, 1'b1};
    vecs[4] = '{28'd10,  1'b1, 1'b1, 1'b1, 4'd15, 6'd63, 1, 10, 0,  2'b01, 1'b1, 1'b1};

    // Reset state
    #2;
    check("reset_outs", 64'({m_rsp_valid, s_req_ready, s_axis_tready, m_axis_tvalid,
                             err_overrun, err_early_last, outstanding}), 64'd0);
    tick(); tick();
    areset = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (3) tick();
    check("post_reset_ready", 64'({s_req_ready, outstanding}), 64'h10);

    // Directed table
    for (int v = 0; v < 5; v++) begin
      c = mk_req(vecs[v].len, vecs[v].ctl, vecs[v].host, vecs[v].stream, vecs[v].dest, vecs[v].pid);
      push_cmd(c);
      send_beat(make_keep(vecs[v].b0), vecs[v].last[0]);
      if (vecs[v].nb > 1) send_beat(make_keep(vecs[v].b1), vecs[v].last[1]);
      check($sformatf("v%0d_rsp_early", v), 64'(m_rsp_valid), 64'd0);
      tick();
      expect_rsp($sformatf("v%0d_rsp", v), rsp_of(c), 0);
      check($sformatf("v%0d_outstanding", v), 64'(outstanding), 64'd0);
      check($sformatf("v%0d_errs", v), 64'({err_overrun, err_early_last}),
            64'({vecs[v].eo, vecs[v].ee}));
    end

    // Fill the queue with silent commands, then drain it with eight full beats
    for (int i = 0; i < 8; i++) push_cmd(mk_req(28'd64, 1'b0, 1'b0, 1'b0, 4'd0, 6'(i)));
    #1;
    check("full_ready", 64'(s_req_ready), 64'd0);
    check("full_outstanding", 64'(outstanding), 64'd8);
    s_axis_tvalid = 1'b1; s_axis_tkeep = make_keep(64); s_axis_tlast = 1'b1;
    cnt = 0; saw = 1'b0;
    #1;
    for (int i = 0; i < 60 && cnt < 8; i++) begin
      if (s_axis_tready) cnt++;
      if (m_rsp_valid) saw = 1'b1;
      tick();
    end
    s_axis_tvalid = 1'b0;
    repeat (3) begin if (m_rsp_valid) saw = 1'b1; tick(); end
    check("drain_beats", 64'(cnt), 64'd8);
    check("drain_no_rsp", 64'(saw), 64'd0);
    check("drain_empty", 64'({s_req_ready, outstanding}), 64'h10);

    // Zero-length command completes without taking data
    s_axis_tvalid = 1'b1; s_axis_tkeep = make_keep(64);
    c = mk_req(28'd0, 1'b1, 1'b0, 1'b1, 4'd6, 6'd17);
    push_cmd(c);
    seen = -1; tr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (s_axis_tready) tr = 1'b1;
      if (m_rsp_valid && seen < 0) seen = i;
      if (seen < 0) tick();
    end
    check("zlen_latency_ok", 64'(seen >= 1 && seen <= 3), 64'd1);
    check("zlen_no_tready", 64'(tr), 64'd0);
    expect_rsp("zlen_rsp", rsp_of(c), 0);
    s_axis_tvalid = 1'b0;

    // Completion back-pressure stalls data until the response is taken
    ca = mk_req(28'd64, 1'b1, 1'b0, 1'b0, 4'd3, 6'd21);
    cb = mk_req(28'd64, 1'b1, 1'b1, 1'b0, 4'd9, 6'd22);
    push_cmd(ca);
    push_cmd(cb);
    send_beat(make_keep(64), 1'b1);
    tick();
    check("bp_valid", 64'(m_rsp_valid), 64'd1);
    held = m_rsp_data;
    s_axis_tvalid = 1'b1; s_axis_tkeep = make_keep(64); s_axis_tlast = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!m_rsp_valid || m_rsp_data !== held || s_axis_tready) bad++;
      tick();
    end
    check("bp_stall", 64'(bad), 64'd0);
    check("bp_data", 64'(held), 64'(rsp_of(ca)));
    m_rsp_ready = 1'b1;
    #1;
    tick();
    m_rsp_ready = 1'b0;
    check("bp_resume_tready", 64'(s_axis_tready), 64'd1);
    tick();
    s_axis_tvalid = 1'b0;
    expect_rsp("bp_next_rsp", rsp_of(cb), 4);

    // Reset in the middle of a command
    push_cmd(mk_req(28'd192, 1'b1, 1'b0, 1'b0, 4'd1, 6'd40));
    send_beat(make_keep(64), 1'b0);
    s_axis_tvalid = 1'b1; s_axis_tkeep = make_keep(64);
    areset = 1'b1;
    #1;
    check("midrst_outs", 64'({m_rsp_valid, s_req_ready, s_axis_tready, m_axis_tvalid,
                              err_overrun, err_early_last, outstanding}), 64'd0);
    tick(); tick();
    areset = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (3) tick();
    check("midrst_after", 64'({m_rsp_valid, s_req_ready, err_overrun, err_early_last, outstanding}),
          64'h40);
    c = mk_req(28'd64, 1'b1, 1'b0, 1'b1, 4'd8, 6'd30);
    push_cmd(c);
    send_beat(make_keep(64), 1'b1);
    expect_rsp("midrst_fresh_rsp", rsp_of(c), 4);
    check("midrst_errs", 64'({err_overrun, err_early_last}), 64'd0);

    // Randomized commands scored against a per-command byte-accounting model
    m_ovr = 1'b0; m_early = 1'b0;
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        c = mk_req(($urandom_range(0, 6) == 0) ? 28'd0 : 28'($urandom_range(1, 300)),
                   1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 6'($urandom));
        model_q.push_back(c);
        push_cmd(c);
      end
      while (model_q.size() > 0) begin
        c = model_q.pop_front();
        acc = 0;
        for (int k = 0; k < 400 && acc < int'(c.len); k++) begin
          keep  = ($urandom_range(0, 1) == 0) ? make_keep(64) : KW'({$urandom, $urandom});
          bytes = $countones(keep);
          last  = (acc + bytes >= int'(c.len)) ? 1'b1 : ($urandom_range(0, 9) == 0);
          acc   = acc + bytes;
          if (acc > int'(c.len)) m_ovr = 1'b1;
          if (acc < int'(c.len) && last) m_early = 1'b1;
          send_beat(keep, last);
        end
        if (c.ctl) begin
          expect_rsp($sformatf("rnd%0d_rsp", r), rsp_of(c), 10);
        end else if (c.len != 28'd0) begin
          check($sformatf("rnd%0d_silent_a", r), 64'(m_rsp_valid), 64'd0);
          tick();
          check($sformatf("rnd%0d_silent_b", r), 64'(m_rsp_valid), 64'd0);
        end
      end
      repeat (3) tick();
      check($sformatf("rnd%0d_state", r), 64'({m_rsp_valid, outstanding, err_overrun, err_early_last}),
            64'({1'b0, 4'd0, m_ovr, m_early}));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
